// File: rtl/instruction_decode.sv
// Decode stage: latches a fetched instruction, reads both source operands and issues one resolved operation to EXE.
// Optional write-back bypass into the operand capture is enabled by defining DECODE_FORWARDING_EN.
module instruction_decode #(
  parameter int INSTRUCTION_WIDTH  = 64,
  parameter int OP_LENGTH          = 16,
  parameter int DATA_ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH         = 96,
  parameter logic [OP_LENGTH-1:0] RETURN_OPCODE = 16'h0001
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iInstructionAvailable,
  input  logic [INSTRUCTION_WIDTH-1:0]  iInstruction,
  input  logic                          iFlush,
  output logic [DATA_ADDRESS_WIDTH-1:0] oRAMReadAddress0,
  output logic [DATA_ADDRESS_WIDTH-1:0] oRAMReadAddress1,
  input  logic [DATA_WIDTH-1:0]         iRAMData0,
  input  logic [DATA_WIDTH-1:0]         iRAMData1,
  output logic                          oIssue,
  output logic [OP_LENGTH-1:0]          oOperation,
  output logic [DATA_ADDRESS_WIDTH-1:0] oDestination,
  output logic [DATA_WIDTH-1:0]         oSource0,
  output logic [DATA_WIDTH-1:0]         oSource1,
  output logic                          oBusy,
  output logic                          oReturnDetected,
  input  logic                          iEXEDone,
  input  logic                          iEXEWriteEnable,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iEXEWriteAddress,
  input  logic [DATA_WIDTH-1:0]         iEXEResult
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, ISSUE, WAIT} state_t;

  state_t state, next_state;

  logic [INSTRUCTION_WIDTH-1:0]  instruction;
  logic [OP_LENGTH-1:0]          opcode;
  logic [DATA_ADDRESS_WIDTH-1:0] destination;
  logic [DATA_WIDTH-1:0]         operand0, operand1;

  assign opcode           = instruction[INSTRUCTION_WIDTH-1 -: OP_LENGTH];
  assign destination      = instruction[2*DATA_ADDRESS_WIDTH +: DATA_ADDRESS_WIDTH];
  assign oRAMReadAddress1 = instruction[DATA_ADDRESS_WIDTH +: DATA_ADDRESS_WIDTH];
  assign oRAMReadAddress0 = instruction[0 +: DATA_ADDRESS_WIDTH];

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Flush overrides every transition; a strobe in WAIT only counts alongside iEXEDone.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iInstructionAvailable) next_state = READ;
      READ:    next_state = LATCH;
      LATCH:   next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (iEXEDone) next_state = iInstructionAvailable ? READ : IDLE;
      default: next_state = IDLE;
    endcase
    if (iFlush) next_state = IDLE;
  end

  always_comb begin
    oBusy = (state != IDLE);
  end

`ifdef DECODE_FORWARDING_EN
  logic [DATA_ADDRESS_WIDTH-1:0] bypass_address;
  logic [DATA_WIDTH-1:0]         bypass_data;
  logic                          bypass_valid;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bypass_valid   <= 1'b0;
      bypass_address <= '0;
      bypass_data    <= '0;
    end else if (iEXEWriteEnable) begin
      bypass_valid   <= 1'b1;
      bypass_address <= iEXEWriteAddress;
      bypass_data    <= iEXEResult;
    end
  end

  // A write landing in the capture cycle is newer than the bypass entry, so it is checked last.
  always_comb begin
    operand0 = iRAMData0;
    operand1 = iRAMData1;
    if (bypass_valid && bypass_address == oRAMReadAddress0) operand0 = bypass_data;
    if (bypass_valid && bypass_address == oRAMReadAddress1) operand1 = bypass_data;
    if (iEXEWriteEnable && iEXEWriteAddress == oRAMReadAddress0) operand0 = iEXEResult;
    if (iEXEWriteEnable && iEXEWriteAddress == oRAMReadAddress1) operand1 = iEXEResult;
  end
`else
  logic unused_exe_write;

  assign unused_exe_write = ^{iEXEWriteEnable, iEXEWriteAddress, iEXEResult};
  assign operand0 = iRAMData0;
  assign operand1 = iRAMData1;
`endif

  // Issue flags are registered off next_state so a flush in LATCH suppresses the pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      instruction     <= '0;
      oIssue          <= 1'b0;
      oReturnDetected <= 1'b0;
      oOperation      <= '0;
      oDestination    <= '0;
      oSource0        <= '0;
      oSource1        <= '0;
    end else begin
      oIssue          <= (next_state == ISSUE);
      oReturnDetected <= (next_state == ISSUE) && (opcode == RETURN_OPCODE);
      if (next_state == READ) instruction <= iInstruction;
      if (state == LATCH && !iFlush) begin
        oOperation   <= opcode;
        oDestination <= destination;
        oSource0     <= operand0;
        oSource1     <= operand1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed table, hand-written corner sequences and
// randomized transactions against a last-write bypass model (DECODE_FORWARDING_EN aware).
module tb_instruction_decode;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         iInstructionAvailable;
  logic [63:0]  iInstruction;
  logic         iFlush;
  logic [15:0]  oRAMReadAddress0, oRAMReadAddress1;
  logic [95:0]  iRAMData0, iRAMData1;
  logic         oIssue;
  logic [15:0]  oOperation, oDestination;
  logic [95:0]  oSource0, oSource1;
  logic         oBusy, oReturnDetected;
  logic         iEXEDone, iEXEWriteEnable;
  logic [15:0]  iEXEWriteAddress;
  logic [95:0]  iEXEResult;

  always #5 Clock = ~Clock;

  instruction_decode dut (
    .Clock(Clock), .Reset(Reset),
    .iInstructionAvailable(iInstructionAvailable), .iInstruction(iInstruction), .iFlush(iFlush),
    .oRAMReadAddress0(oRAMReadAddress0), .oRAMReadAddress1(oRAMReadAddress1),
    .iRAMData0(iRAMData0), .iRAMData1(iRAMData1),
    .oIssue(oIssue), .oOperation(oOperation), .oDestination(oDestination),
    .oSource0(oSource0), .oSource1(oSource1), .oBusy(oBusy), .oReturnDetected(oReturnDetected),
    .iEXEDone(iEXEDone), .iEXEWriteEnable(iEXEWriteEnable),
    .iEXEWriteAddress(iEXEWriteAddress), .iEXEResult(iEXEResult)
  );

  localparam logic [95:0] VAL_A = 96'hAAAA_0001_AAAA_0002_AAAA_0003;
  localparam logic [95:0] VAL_B = 96'hBBBB_0004_BBBB_0005_BBBB_0006;
  localparam logic [95:0] VAL_C = 96'hCCCC_1234_CCCC_5678_CCCC_9ABC;

  // Register file with one-cycle read latency; EXE write-backs never reach it here.
  logic [95:0] ram [16];
  always_ff @(posedge Clock) begin
    iRAMData0 <= ram[oRAMReadAddress0[3:0]];
    iRAMData1 <= ram[oRAMReadAddress1[3:0]];
  end

  typedef struct {
    logic [63:0] instr;
    logic [15:0] op;
    logic [15:0] dest;
    logic [95:0] s0;
    logic [95:0] s1;
    logic        ret;
  } vec_t;

  vec_t        vecs [4];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          rand_exe = 1'b0;
  bit          m_valid  = 1'b0;
  logic [15:0] m_addr   = '0;
  logic [95:0] m_data   = '0;
  logic [15:0] last_op;
  logic [95:0] last_s0;

  function automatic logic [95:0] ram_init(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i), 32'(i) * 32'h0101_0101 + 32'h1};
  endfunction

  // The newest EXE write wins; otherwise the register file value is seen.
  function automatic logic [95:0] model_src(input logic [15:0] a);
`ifdef DECODE_FORWARDING_EN
    if (iEXEWriteEnable && iEXEWriteAddress == a) return iEXEResult;
    if (m_valid && m_addr == a) return m_data;
`endif
    return ram[a[3:0]];
  endfunction

  task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle, record any EXE write into the model, then drive new EXE traffic.
  task automatic step();
    @(posedge Clock);
    if (Reset) m_valid = 1'b0;
    else if (iEXEWriteEnable) begin
      m_valid = 1'b1;
      m_addr  = iEXEWriteAddress;
      m_data  = iEXEResult;
    end
    #1;
    if (rand_exe) begin
      iEXEWriteEnable  = ($urandom % 3 == 0);
      iEXEWriteAddress = 16'($urandom % 16);
      iEXEResult       = {$urandom, $urandom, $urandom};
    end else begin
      iEXEWriteEnable = 1'b0;
    end
  endtask

  // One full transaction starting in the strobe cycle (IDLE, or WAIT with iEXEDone already high).
  task automatic apply_stimulus(input logic [63:0] instr, input logic [15:0] e_op, input logic [15:0] e_dest,
                                input logic e_ret, input bit use_model, input logic [95:0] t_s0,
                                input logic [95:0] t_s1, input int wait_cycles, input bit chain,
                                input bit done_in_issue, input string tag);
    logic [95:0] e0, e1;
    iInstructionAvailable = 1'b1;
    iInstruction = instr;
    step();
    iInstructionAvailable = 1'b0;
    iEXEDone = 1'b0;
    check_output({tag, ".read_addr0"}, oRAMReadAddress0, instr[15:0]);
    check_output({tag, ".read_addr1"}, oRAMReadAddress1, instr[31:16]);
    check_output({tag, ".read_busy"}, oBusy, 1'b1);
    check_output({tag, ".read_issue"}, oIssue, 1'b0);
    step();
    check_output({tag, ".latch_issue"}, oIssue, 1'b0);
    check_output({tag, ".latch_busy"}, oBusy, 1'b1);
    if (use_model) begin
      e0 = model_src(instr[15:0]);
      e1 = model_src(instr[31:16]);
    end else begin
      e0 = t_s0;
      e1 = t_s1;
    end
    step();
    check_output({tag, ".issue"}, oIssue, 1'b1);
    check_output({tag, ".op"}, oOperation, e_op);
    check_output({tag, ".dest"}, oDestination, e_dest);
    check_output({tag, ".src0"}, oSource0, e0);
    check_output({tag, ".src1"}, oSource1, e1);
    check_output({tag, ".ret"}, oReturnDetected, e_ret);
    check_output({tag, ".issue_busy"}, oBusy, 1'b1);
    last_op = e_op;
    last_s0 = e0;
    iEXEDone = done_in_issue;
    step();
    iEXEDone = 1'b0;
    check_output({tag, ".wait_issue"}, oIssue, 1'b0);
    check_output({tag, ".wait_ret"}, oReturnDetected, 1'b0);
    check_output({tag, ".wait_busy"}, oBusy, 1'b1);
    check_output({tag, ".wait_op_hold"}, oOperation, e_op);
    for (int k = 0; k < wait_cycles; k++) begin
      step();
      check_output({tag, ".wait_more_busy"}, oBusy, 1'b1);
      check_output({tag, ".wait_more_issue"}, oIssue, 1'b0);
    end
    iEXEDone = 1'b1;
    if (!chain) begin
      step();
      iEXEDone = 1'b0;
      check_output({tag, ".done_idle"}, oBusy, 1'b0);
      check_output({tag, ".done_issue"}, oIssue, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] instr;
    logic [15:0] op;
    bit          chain;
    Reset = 1'b1;
    iInstructionAvailable = 1'b0;
    iInstruction = '0;
    iFlush = 1'b0;
    iEXEDone = 1'b0;
    iEXEWriteEnable = 1'b0;
    iEXEWriteAddress = '0;
    iEXEResult = '0;
    for (int i = 0; i < 16; i++) ram[i] = ram_init(i);
    ram[2] = VAL_A;
    ram[3] = VAL_B;

    vecs[0] = '{64'h0005_0010_0003_0002, 16'h0005, 16'h0010, VAL_A, VAL_B, 1'b0};
    vecs[1] = '{64'h0001_00FF_0007_0007, 16'h0001, 16'h00FF, ram_init(7), ram_init(7), 1'b1};
    vecs[2] = '{64'hFFFF_FFFF_000F_0000, 16'hFFFF, 16'hFFFF, ram_init(0), ram_init(15), 1'b0};
    vecs[3] = '{64'h0000_1234_0009_000C, 16'h0000, 16'h1234, ram_init(12), ram_init(9), 1'b0};

    repeat (2) step();
    Reset = 1'b0;
    repeat (10) step();
    check_output("reset.issue", oIssue, 1'b0);
    check_output("reset.busy", oBusy, 1'b0);
    check_output("reset.op", oOperation, 16'h0);
    check_output("reset.dest", oDestination, 16'h0);
    check_output("reset.src0", oSource0, 96'h0);
    check_output("reset.src1", oSource1, 96'h0);
    check_output("reset.ret", oReturnDetected, 1'b0);
    check_output("reset.addr0", oRAMReadAddress0, 16'h0);
    check_output("reset.addr1", oRAMReadAddress1, 16'h0);

    for (int i = 0; i < 4; i++)
      apply_stimulus(vecs[i].instr, vecs[i].op, vecs[i].dest, vecs[i].ret, 1'b0,
                     vecs[i].s0, vecs[i].s1, i, 1'b0, 1'b0, $sformatf("table%0d", i));

    // Back-to-back: done and the next strobe share a WAIT cycle.
    apply_stimulus(64'h0003_0042_0005_0004, 16'h0003, 16'h0042, 1'b0, 1'b0,
                   ram_init(4), ram_init(5), 1, 1'b1, 1'b0, "b2b_first");
    apply_stimulus(64'h0001_0043_0006_0008, 16'h0001, 16'h0043, 1'b1, 1'b0,
                   ram_init(8), ram_init(6), 0, 1'b0, 1'b0, "b2b_second");

    // Flush while in LATCH: no issue, operands untouched.
    iInstructionAvailable = 1'b1;
    iInstruction = 64'h0009_0030_0005_0004;
    step();
    iInstructionAvailable = 1'b0;
    step();
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    check_output("flush_latch.busy", oBusy, 1'b0);
    check_output("flush_latch.issue", oIssue, 1'b0);
    check_output("flush_latch.op_hold", oOperation, last_op);
    check_output("flush_latch.src0_hold", oSource0, last_s0);
    repeat (3) begin
      step();
      check_output("flush_latch.no_issue", oIssue, 1'b0);
    end

    // Flush together with a strobe drops that instruction.
    iInstructionAvailable = 1'b1;
    iFlush = 1'b1;
    iInstruction = 64'h0002_0000_000E_000D;
    step();
    iInstructionAvailable = 1'b0;
    iFlush = 1'b0;
    check_output("flush_strobe.busy", oBusy, 1'b0);
    check_output("flush_strobe.addr0", oRAMReadAddress0, 16'h0004);
    apply_stimulus(64'h0006_0011_0003_0002, 16'h0006, 16'h0011, 1'b0, 1'b0,
                   VAL_A, VAL_B, 0, 1'b0, 1'b0, "after_flush");

    // EXE writes address 2 during READ; RAM still returns the old value.
    iInstructionAvailable = 1'b1;
    iInstruction = 64'h0007_0020_0003_0002;
    step();
    iInstructionAvailable = 1'b0;
    iEXEWriteEnable = 1'b1;
    iEXEWriteAddress = 16'h0002;
    iEXEResult = '1;
    step();
    step();
`ifdef DECODE_FORWARDING_EN
    check_output("fwd_bypass.src0", oSource0, {96{1'b1}});
`else
    check_output("fwd_bypass.src0", oSource0, VAL_A);
`endif
    check_output("fwd_bypass.src1", oSource1, VAL_B);
    check_output("fwd_bypass.issue", oIssue, 1'b1);
    iEXEDone = 1'b1;
    step();
    step();
    iEXEDone = 1'b0;
    check_output("fwd_bypass.idle", oBusy, 1'b0);

    // EXE writes address 3 in the LATCH cycle itself.
    iInstructionAvailable = 1'b1;
    iInstruction = 64'h0008_0021_0003_0002;
    step();
    iInstructionAvailable = 1'b0;
    step();
    iEXEWriteEnable = 1'b1;
    iEXEWriteAddress = 16'h0003;
    iEXEResult = VAL_C;
    step();
`ifdef DECODE_FORWARDING_EN
    check_output("fwd_direct.src1", oSource1, VAL_C);
    check_output("fwd_direct.src0", oSource0, {96{1'b1}});
`else
    check_output("fwd_direct.src1", oSource1, VAL_B);
    check_output("fwd_direct.src0", oSource0, VAL_A);
`endif
    iEXEDone = 1'b1;
    step();
    step();
    iEXEDone = 1'b0;

    // Randomized transactions with background EXE write-back traffic.
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom, $urandom};
    rand_exe = 1'b1;
    chain = 1'b0;
    for (int t = 0; t < 40; t++) begin
      op = ($urandom % 4 == 0) ? 16'h0001 : 16'($urandom);
      instr = {op, 16'($urandom), 12'h0, 4'($urandom), 12'h0, 4'($urandom)};
      chain = (t != 39) && ($urandom % 2 == 1);
      apply_stimulus(instr, instr[63:48], instr[47:32], instr[63:48] == 16'h0001, 1'b1,
                     '0, '0, int'($urandom % 3), chain, bit'($urandom % 2), $sformatf("rand%0d", t));
    end
    rand_exe = 1'b0;
    step();

    // Reset during LATCH after a bypass write: back to IDLE, no pulse, bypass forgotten.
    iInstructionAvailable = 1'b1;
    iInstruction = 64'h0004_0050_0006_0005;
    step();
    iInstructionAvailable = 1'b0;
    iEXEWriteEnable = 1'b1;
    iEXEWriteAddress = 16'h0005;
    iEXEResult = VAL_C;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_output("mid_reset.busy", oBusy, 1'b0);
    check_output("mid_reset.issue", oIssue, 1'b0);
    check_output("mid_reset.op", oOperation, 16'h0);
    check_output("mid_reset.src0", oSource0, 96'h0);
    check_output("mid_reset.addr0", oRAMReadAddress0, 16'h0);
    check_output("mid_reset.ret", oReturnDetected, 1'b0);
    repeat (4) begin
      step();
      check_output("mid_reset.no_issue", oIssue, 1'b0);
    end
    apply_stimulus(64'h0004_0050_0006_0005, 16'h0004, 16'h0050, 1'b0, 1'b0,
                   ram[5], ram[6], 0, 1'b0, 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
